// File: rtl/cprv_decode_stage.sv
// RV64I decode stage: regfile read, N-entry bypass, immediate generation,
// load-use stall and a valid/ready pipeline register towards EX.
module cprv_decode_stage #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned NUM_FWD     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_id_i,
  output logic                           ready_id_o,
  input  logic [INSTR_WIDTH-1:0]         instr_data_id_i,
  input  logic [DATA_WIDTH-1:0]          pc_id_i,
  input  logic                           flush_i,
  output logic [4:0]                     rs1_addr_rf_o,
  output logic [4:0]                     rs2_addr_rf_o,
  input  logic [DATA_WIDTH-1:0]          rs1_data_rf_i,
  input  logic [DATA_WIDTH-1:0]          rs2_data_rf_i,
  input  logic [NUM_FWD-1:0]             fwd_valid_i,
  input  logic [NUM_FWD-1:0]             fwd_pending_i,
  input  logic [NUM_FWD*5-1:0]           fwd_addr_i,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]  fwd_data_i,
  output logic                           valid_ex_o,
  input  logic                           ready_ex_i,
  output logic [DATA_WIDTH-1:0]          pc_ex_o,
  output logic [DATA_WIDTH-1:0]          rs1_data_ex_o,
  output logic [DATA_WIDTH-1:0]          rs2_data_ex_o,
  output logic [DATA_WIDTH-1:0]          imm_data_ex_o,
  output logic [4:0]                     rd_addr_ex_o,
  output logic [6:0]                     opcode_ex_o,
  output logic [2:0]                     funct3_ex_o,
  output logic [6:0]                     funct7_ex_o,
  output logic                           rd_en_ex_o,
  output logic                           mem_r_en_ex_o,
  output logic                           mem_w_en_ex_o,
  output logic                           illegal_ex_o
);

  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rd;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  rd_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  illegal;
  } payload_t;

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic                  rs1_pend;
  logic                  rs2_pend;
  logic                  stall;
  logic                  cke;
  logic                  writes_rd;
  logic                  legal_opc;
  payload_t              dec;
  payload_t              pay_d, pay_q;
  logic                  valid_d, valid_q;

  assign instr    = instr_data_id_i[31:0];
  assign opcode   = instr[6:0];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign rs1_addr_rf_o = rs1_addr;
  assign rs2_addr_rf_o = rs2_addr;

  // Bypass select: scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs1_val  = rs1_data_rf_i;
    rs2_val  = rs2_data_rf_i;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_addr_i[REG_AW*i +: REG_AW] == rs1_addr)) begin
        rs1_val  = fwd_data_i[DATA_WIDTH*i +: DATA_WIDTH];
        rs1_pend = fwd_pending_i[i];
      end
      if (fwd_valid_i[i] && (fwd_addr_i[REG_AW*i +: REG_AW] == rs2_addr)) begin
        rs2_val  = fwd_data_i[DATA_WIDTH*i +: DATA_WIDTH];
        rs2_pend = fwd_pending_i[i];
      end
    end
    if (rs1_addr == 5'd0) begin
      rs1_val  = '0;
      rs1_pend = 1'b0;
    end
    if (rs2_addr == 5'd0) begin
      rs2_val  = '0;
      rs2_pend = 1'b0;
    end
  end

  assign stall      = valid_id_i & (rs1_pend | rs2_pend);
  assign cke        = ~valid_q | ready_ex_i;
  assign ready_id_o = flush_i | (cke & ~stall);

  // Instruction decode: immediate per format, enables and illegal flag.
  always_comb begin
    dec        = '0;
    writes_rd  = 1'b0;
    legal_opc  = 1'b0;
    dec.pc     = pc_id_i;
    dec.rs1    = rs1_val;
    dec.rs2    = rs2_val;
    dec.rd     = instr[11:7];
    dec.opcode = opcode;
    dec.funct3 = instr[14:12];
    dec.funct7 = instr[31:25];

    unique case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR:
        dec.imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
      OPC_STORE:
        dec.imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        dec.imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        dec.imm = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
      OPC_JAL:
        dec.imm = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
      default:
        dec.imm = '0;
    endcase

    unique case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_LOAD,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        writes_rd = 1'b1;
        legal_opc = 1'b1;
      end
      OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM:
        legal_opc = 1'b1;
      default: ;
    endcase

    dec.illegal  = (instr[1:0] != 2'b11) | ~legal_opc;
    dec.rd_en    = writes_rd & (dec.rd != 5'd0) & ~dec.illegal;
    dec.mem_r_en = (opcode == OPC_LOAD) & ~dec.illegal;
    dec.mem_w_en = (opcode == OPC_STORE) & ~dec.illegal;
  end

  // Pipeline register next state: flush, then hold, then bubble, then load.
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (cke) begin
      if (stall) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_id_i;
        pay_d   = dec;
      end
    end
  end

  // EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign valid_ex_o    = valid_q;
  assign pc_ex_o       = pay_q.pc;
  assign rs1_data_ex_o = pay_q.rs1;
  assign rs2_data_ex_o = pay_q.rs2;
  assign imm_data_ex_o = pay_q.imm;
  assign rd_addr_ex_o  = pay_q.rd;
  assign opcode_ex_o   = pay_q.opcode;
  assign funct3_ex_o   = pay_q.funct3;
  assign funct7_ex_o   = pay_q.funct7;
  assign rd_en_ex_o    = pay_q.rd_en;
  assign mem_r_en_ex_o = pay_q.mem_r_en;
  assign mem_w_en_ex_o = pay_q.mem_w_en;
  assign illegal_ex_o  = pay_q.illegal;

endmodule

// File: tb/tb_cprv_decode_stage.sv
// Bench for cprv_decode_stage: directed scenarios plus random traffic,
// all checked against a cycle-level reference model.
module tb_cprv_decode_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_id_i, ready_id_o, flush_i, ready_ex_i;
  logic [31:0]  instr_data_id_i;
  logic [63:0]  pc_id_i, rs1_data_rf_i, rs2_data_rf_i;
  logic [4:0]   rs1_addr_rf_o, rs2_addr_rf_o, rd_addr_ex_o;
  logic [1:0]   fwd_valid_i, fwd_pending_i;
  logic [9:0]   fwd_addr_i;
  logic [127:0] fwd_data_i;
  logic         valid_ex_o, rd_en_ex_o, mem_r_en_ex_o, mem_w_en_ex_o, illegal_ex_o;
  logic [63:0]  pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o;
  logic [6:0]   opcode_ex_o, funct7_ex_o;
  logic [2:0]   funct3_ex_o;

  cprv_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .valid_id_i(valid_id_i), .ready_id_o(ready_id_o),
    .instr_data_id_i(instr_data_id_i), .pc_id_i(pc_id_i), .flush_i(flush_i),
    .rs1_addr_rf_o(rs1_addr_rf_o), .rs2_addr_rf_o(rs2_addr_rf_o),
    .rs1_data_rf_i(rs1_data_rf_i), .rs2_data_rf_i(rs2_data_rf_i),
    .fwd_valid_i(fwd_valid_i), .fwd_pending_i(fwd_pending_i),
    .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .valid_ex_o(valid_ex_o), .ready_ex_i(ready_ex_i),
    .pc_ex_o(pc_ex_o), .rs1_data_ex_o(rs1_data_ex_o), .rs2_data_ex_o(rs2_data_ex_o),
    .imm_data_ex_o(imm_data_ex_o), .rd_addr_ex_o(rd_addr_ex_o),
    .opcode_ex_o(opcode_ex_o), .funct3_ex_o(funct3_ex_o), .funct7_ex_o(funct7_ex_o),
    .rd_en_ex_o(rd_en_ex_o), .mem_r_en_ex_o(mem_r_en_ex_o),
    .mem_w_en_ex_o(mem_w_en_ex_o), .illegal_ex_o(illegal_ex_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] rf [32];

  // Reference model state: what EX should hold after the next edge.
  logic        m_valid;
  logic [63:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [31:0] m_ins;
  logic        m_rd_en, m_mr, m_mw, m_ill;

  localparam logic [6:0] RD_OPS  [9] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h03,
                                         7'h37, 7'h17, 7'h6F, 7'h67};
  localparam logic [6:0] ALL_OPS [13] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h03,
                                          7'h37, 7'h17, 7'h6F, 7'h67,
                                          7'h23, 7'h63, 7'h0F, 7'h73};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic in_list9(input logic [6:0] op);
    foreach (RD_OPS[k]) if (RD_OPS[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic in_list13(input logic [6:0] op);
    foreach (ALL_OPS[k]) if (ALL_OPS[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Immediate as a signed integer built from the scattered fields.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    longint v = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: begin
        v = longint'(ins[31:20]);
        if (ins[31]) v -= 4096;
      end
      7'h23: begin
        v = longint'({ins[31:25], ins[11:7]});
        if (ins[31]) v -= 4096;
      end
      7'h63: begin
        v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        if (ins[31]) v -= 8192;
      end
      7'h37, 7'h17: begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= 64'sh1_0000_0000;
      end
      7'h6F: begin
        v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
        if (ins[31]) v -= 64'sh20_0000;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  // First matching bypass entry in priority order, else the regfile.
  task automatic ref_opnd(input logic [4:0] a, input logic [1:0] fv, input logic [1:0] fp,
                          input logic [9:0] fa, input logic [127:0] fd,
                          output logic [63:0] val, output logic pend);
    val  = rf[a];
    pend = 1'b0;
    if (a == 5'd0) begin
      val = 64'd0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (fv[i] && fa[5*i +: 5] == a) begin
        val  = fd[64*i +: 64];
        pend = fp[i];
        return;
      end
    end
  endtask

  task automatic step(input logic vld, input logic [31:0] ins, input logic [63:0] pc,
                      input logic fl, input logic rdy, input logic [1:0] fv,
                      input logic [1:0] fp, input logic [9:0] fa, input logic [127:0] fd);
    logic [63:0] v1, v2;
    logic        p1, p2, stl, ck, exp_rdy, ill;
    @(negedge clk);
    valid_id_i      = vld;
    instr_data_id_i = ins;
    pc_id_i         = pc;
    flush_i         = fl;
    ready_ex_i      = rdy;
    fwd_valid_i     = fv;
    fwd_pending_i   = fp;
    fwd_addr_i      = fa;
    fwd_data_i      = fd;
    rs1_data_rf_i   = rf[ins[19:15]];
    rs2_data_rf_i   = rf[ins[24:20]];
    #1;
    ref_opnd(ins[19:15], fv, fp, fa, fd, v1, p1);
    ref_opnd(ins[24:20], fv, fp, fa, fd, v2, p2);
    stl     = vld && (p1 || p2);
    ck      = !m_valid || rdy;
    exp_rdy = fl || (ck && !stl);
    check("ready_id", 64'(ready_id_o), 64'(exp_rdy));
    check("rs1_addr", 64'(rs1_addr_rf_o), 64'(ins[19:15]));
    check("rs2_addr", 64'(rs2_addr_rf_o), 64'(ins[24:20]));
    if (fl) m_valid = 1'b0;
    else if (ck) begin
      if (stl) m_valid = 1'b0;
      else begin
        m_valid = vld;
        ill     = (ins[1:0] != 2'b11) || !in_list13(ins[6:0]);
        m_ins   = ins;
        m_pc    = pc;
        m_rs1   = v1;
        m_rs2   = v2;
        m_imm   = ref_imm(ins);
        m_ill   = ill;
        m_rd_en = !ill && in_list9(ins[6:0]) && (ins[11:7] != 5'd0);
        m_mr    = !ill && (ins[6:0] == 7'h03);
        m_mw    = !ill && (ins[6:0] == 7'h23);
      end
    end
    @(posedge clk);
    #1;
    check("valid_ex", 64'(valid_ex_o), 64'(m_valid));
    if (m_valid) begin
      check("pc_ex", pc_ex_o, m_pc);
      check("rs1_ex", rs1_data_ex_o, m_rs1);
      check("rs2_ex", rs2_data_ex_o, m_rs2);
      check("imm_ex", imm_data_ex_o, m_imm);
      check("rd_ex", 64'(rd_addr_ex_o), 64'(m_ins[11:7]));
      check("opcode_ex", 64'(opcode_ex_o), 64'(m_ins[6:0]));
      check("funct3_ex", 64'(funct3_ex_o), 64'(m_ins[14:12]));
      check("funct7_ex", 64'(funct7_ex_o), 64'(m_ins[31:25]));
      check("rd_en_ex", 64'(rd_en_ex_o), 64'(m_rd_en));
      check("mem_r_ex", 64'(mem_r_en_ex_o), 64'(m_mr));
      check("mem_w_ex", 64'(mem_w_en_ex_o), 64'(m_mw));
      check("illegal_ex", 64'(illegal_ex_o), 64'(m_ill));
    end
  endtask

  // Short form for a plain instruction with no bypass activity.
  task automatic plain(input logic [31:0] ins, input logic [63:0] pc, input logic rdy);
    step(1'b1, ins, pc, 1'b0, rdy, 2'b00, 2'b00, 10'd0, 128'd0);
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFF08293;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADD0 = 32'h002001B3;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_JAL  = 32'h001000EF;
  localparam logic [31:0] I_LUI  = 32'h800000B7;

  initial begin
    logic [31:0]  ins;
    logic [9:0]   fa;
    logic [127:0] fd;
    logic [1:0]   fv, fp;
    logic [6:0]   op;

    rst_n = 1'b0;
    valid_id_i = 1'b0; instr_data_id_i = '0; pc_id_i = '0; flush_i = 1'b0;
    ready_ex_i = 1'b1; fwd_valid_i = '0; fwd_pending_i = '0; fwd_addr_i = '0;
    fwd_data_i = '0; rs1_data_rf_i = '0; rs2_data_rf_i = '0;
    for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom};
    rf[1] = 64'd10;
    m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_ex_o), 64'd0);
    check("rst_pc", pc_ex_o, 64'd0);
    check("rst_imm", imm_data_ex_o, 64'd0);
    check("rst_flags", 64'({rd_en_ex_o, mem_r_en_ex_o, mem_w_en_ex_o, illegal_ex_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x5,x1,-1
    plain(I_ADDI, 64'h1000, 1'b1);
    check("addi_valid", 64'(valid_ex_o), 64'd1);
    check("addi_rs1", rs1_data_ex_o, 64'd10);
    check("addi_imm", imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_rd", 64'(rd_addr_ex_o), 64'd5);
    check("addi_rd_en", 64'(rd_en_ex_o), 64'd1);

    // Bypass priority and x0
    step(1'b1, I_ADD, 64'h1004, 1'b0, 1'b1, 2'b11, 2'b00, {5'd1, 5'd1}, {64'hBB, 64'hAA});
    check("fwd_young", rs1_data_ex_o, 64'hAA);
    step(1'b1, I_ADD, 64'h1008, 1'b0, 1'b1, 2'b11, 2'b00, {5'd2, 5'd1}, {64'hCC, 64'hAA});
    check("fwd_rs2", rs2_data_ex_o, 64'hCC);
    step(1'b1, I_ADD0, 64'h100C, 1'b0, 1'b1, 2'b01, 2'b00, {5'd0, 5'd0}, {64'h0, 64'h55});
    check("fwd_x0", rs1_data_ex_o, 64'd0);

    // Load-use stall for two cycles
    for (int k = 0; k < 2; k++) begin
      step(1'b1, I_ADD, 64'h1010, 1'b0, 1'b1, 2'b01, 2'b01, {5'd0, 5'd1}, {64'h0, 64'h77});
      check("lu_ready", 64'(ready_id_o), 64'd0);
      check("lu_bubble", 64'(valid_ex_o), 64'd0);
    end
    step(1'b1, I_ADD, 64'h1010, 1'b0, 1'b1, 2'b01, 2'b00, {5'd0, 5'd1}, {64'h0, 64'h77});
    check("lu_accept", rs1_data_ex_o, 64'h77);

    // Backpressure for three cycles, then release
    plain(I_LUI, 64'h1014, 1'b1);
    for (int k = 0; k < 3; k++) begin
      plain(I_JAL, 64'h2000, 1'b0);
      check("bp_hold_pc", pc_ex_o, 64'h1014);
    end
    plain(I_JAL, 64'h2000, 1'b1);
    check("bp_release_pc", pc_ex_o, 64'h2000);

    // Flush overrides backpressure
    plain(I_BEQ, 64'h2004, 1'b0);
    step(1'b1, I_ADDI, 64'h2008, 1'b1, 1'b0, 2'b00, 2'b00, 10'd0, 128'd0);
    check("flush_valid", 64'(valid_ex_o), 64'd0);
    plain(I_SW, 64'h200C, 1'b1);
    check("sw_mem_w", 64'(mem_w_en_ex_o), 64'd1);
    check("sw_imm", imm_data_ex_o, 64'd8);
    check("sw_rd_en", 64'(rd_en_ex_o), 64'd0);

    // Immediate formats and illegal encodings
    plain(I_BEQ, 64'h2010, 1'b1);
    check("beq_imm", imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFFC);
    plain(I_JAL, 64'h2014, 1'b1);
    check("jal_imm", imm_data_ex_o, 64'd2048);
    plain(I_LUI, 64'h2018, 1'b1);
    check("lui_imm", imm_data_ex_o, 64'hFFFF_FFFF_8000_0000);
    plain(32'h000000FF, 64'h201C, 1'b1);
    check("ill_7f", 64'({illegal_ex_o, rd_en_ex_o, mem_r_en_ex_o, mem_w_en_ex_o}), 64'b1000);
    plain(32'h00002080, 64'h2020, 1'b1);
    check("ill_lowbits", 64'({illegal_ex_o, rd_en_ex_o, mem_r_en_ex_o, mem_w_en_ex_o}), 64'b1000);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 15))
        13:      op = 7'h7F;
        14:      op = 7'h0B;
        15:      op = 7'(ALL_OPS[$urandom_range(0, 12)] & 7'h7C);
        default: op = ALL_OPS[$urandom_range(0, 12)];
      endcase
      ins        = $urandom;
      ins[6:0]   = op;
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      ins[11:7]  = 5'($urandom_range(0, 7));
      fv = 2'($urandom);
      fp = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      fa = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fd = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, ins, {$urandom, $urandom},
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, fv, fp, fa, fd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
